cpu_regfile: RTL and testbench
==============================

Name: cpu_regfile

Overview:
- Architectural register file for the moxie pipeline, sitting directly downstream of the writeback stage.
- Consumes the writeback stage's register write index, write enable and result, and serves two registered read ports to decode.
- Contains a per-register pending-write scoreboard. Decode reserves a destination at issue; writeback releases it on commit. Decode reads busy flags to detect RAW hazards and stall.

Parameters:
- DATA_WIDTH, 32, register width in bits
- NREGS, 16, number of registers; index width is $clog2(NREGS) = 4
- PEND_WIDTH, 2, width of each per-register pending-write counter (max 3 outstanding writes)

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  reset; asynchronous, active-low
- read_index_a_i  input  4  port A source register index
- read_index_b_i  input  4  port B source register index
- value_a_o  output  32  port A data, registered
- value_b_o  output  32  port B data, registered
- register_write_index_i  input  4  commit destination, from writeback
- register_we_i  input  1  commit enable, from writeback
- reg_result_i  input  32  commit data, from writeback
- reserve_i  input  1  decode issues an instruction that writes a register
- reserve_index_i  input  4  destination being reserved
- busy_a_o  output  1  port A index has a pending write (combinational)
- busy_b_o  output  1  port B index has a pending write (combinational)
- reserve_full_o  output  1  counter of reserve_index_i is saturated; decode must stall (combinational)
- sb_error_o  output  1  sticky: commit to a register with zero pending writes, or reserve while full

Behaviour:
- Reset (rst_i low, asynchronous):
  - all registers, value_a_o, value_b_o and every pending counter go to 0
  - sb_error_o goes to 0
  - all busy outputs read 0
  - any in-flight reserve or commit is discarded
- Write: on a clock edge with register_we_i=1, regs[register_write_index_i] <= reg_result_i. No register is hardwired to zero.
- Read latency is one cycle: value_x_o <= regs[read_index_x_i] on every edge. There is no read enable; outputs update every cycle.
- busy_x_o = (pend[read_index_x_i] != 0).
- reserve_full_o = (pend[reserve_index_i] == 2^PEND_WIDTH-1).
- Scoreboard update, per register r, at each edge. Let inc = reserve_i && reserve_index_i==r and dec = register_we_i && register_write_index_i==r.
  - inc only: pend[r] + 1. If already saturated: hold the value and set sb_error_o.
  - dec only: pend[r] - 1. If already 0: hold 0 and set sb_error_o.
  - inc and dec together: pend[r] unchanged; no error even if the counter is 0 or full.
- Both read ports may address the same register; both return identical data.
- sb_error_o clears only on reset.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: if register_we_i=1 and register_write_index_i == read_index_x_i in the same cycle, value_x_o captures reg_result_i instead of the stale array value. Bypass applies to each port independently.
- Undefined: value_x_o captures the pre-write array contents; the new value becomes visible one cycle later. Decode must cover the gap via busy_x_o, which stays asserted until the commit edge.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_WIDTH
  - NREGS
  - REG_INDEX_WIDTH
  - PEND_WIDTH
  - the register-index typedef used by decode, writeback and regfile
- One sub-module, cpu_scoreboard: the pending counters plus busy_a_o, busy_b_o, reserve_full_o and sb_error_o.
- The storage array and read registers stay in cpu_regfile.

Test Plan:
- Reset mid-operation: write r5=0xDEADBEEF, reserve r3, assert rst_i low between edges → value_a_o/value_b_o = 0, busy on r3 = 0, sb_error_o = 0; next read of r5 after release returns 0.
- Basic write/read: commit r7=0x12345678, then read_index_a_i=7 → value_a_o = 0x12345678 one cycle after the read index is presented.
- Same-cycle bypass: commit r2=0xA5A5A5A5 while read_index_b_i=2, r2 previously 0 → value_b_o = 0xA5A5A5A5 with REGFILE_BYPASS_EN defined, 0x00000000 without.
- Scoreboard counting: reserve r4 three times → reserve_full_o = 1 with reserve_index_i=4; fourth reserve → sb_error_o = 1, count stays 3; three commits to r4 → busy_a_o (index 4) drops to 0 after the third.
- Simultaneous reserve and commit: r9 pending=1, then reserve_i and commit of r9 in the same cycle → pending stays 1, busy stays 1, sb_error_o = 0.
- Spurious commit: commit r1 with pending=0 → r1 data written, sb_error_o = 1 and held until reset.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared register-file parameters and the register-index type used by decode,
// writeback and the register file.
package cpu_pkg;

    localparam int unsigned DATA_WIDTH      = 32;
    localparam int unsigned NREGS           = 16;
    localparam int unsigned REG_INDEX_WIDTH = $clog2(NREGS);
    localparam int unsigned PEND_WIDTH      = 2;

    typedef logic [REG_INDEX_WIDTH-1:0] reg_idx_t;
    typedef logic [DATA_WIDTH-1:0]      reg_data_t;
    typedef logic [PEND_WIDTH-1:0]      pend_cnt_t;

    localparam pend_cnt_t PEND_MAX = '1;

endpackage

// File: rtl/cpu_scoreboard.sv
// Per-register pending-write counters: decode reserves, writeback releases.
// Drives the busy/full hazard flags and a sticky protocol-error flag.
module cpu_scoreboard
    import cpu_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_i,
    input  reg_idx_t read_index_a_i,
    input  reg_idx_t read_index_b_i,
    input  logic     reserve_i,
    input  reg_idx_t reserve_index_i,
    input  logic     commit_i,
    input  reg_idx_t commit_index_i,
    output logic     busy_a_o,
    output logic     busy_b_o,
    output logic     reserve_full_o,
    output logic     sb_error_o
);

    pend_cnt_t        pend_q [NREGS];
    pend_cnt_t        pend_d [NREGS];
    logic [NREGS-1:0] inc_vec;
    logic [NREGS-1:0] dec_vec;
    logic             err_set;
    logic             sb_error_q;
    logic             sb_error_d;

    always_comb begin
        inc_vec = reserve_i ? (NREGS'(1) << reserve_index_i) : '0;
        dec_vec = commit_i  ? (NREGS'(1) << commit_index_i)  : '0;
        err_set = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            pend_d[r] = pend_q[r];
            // Reserve and commit on the same register cancel out, even at 0 or full.
            unique case ({inc_vec[r], dec_vec[r]})
                2'b10: begin
                    if (pend_q[r] == PEND_MAX) err_set = 1'b1;
                    else                       pend_d[r] = pend_q[r] + 1'b1;
                end
                2'b01: begin
                    if (pend_q[r] == '0) err_set = 1'b1;
                    else                 pend_d[r] = pend_q[r] - 1'b1;
                end
                default: ;
            endcase
        end
        sb_error_d = sb_error_q | err_set;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int r = 0; r < NREGS; r++) pend_q[r] <= '0;
            sb_error_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) pend_q[r] <= pend_d[r];
            sb_error_q <= sb_error_d;
        end
    end

    assign busy_a_o       = (pend_q[read_index_a_i] != '0);
    assign busy_b_o       = (pend_q[read_index_b_i] != '0);
    assign reserve_full_o = (pend_q[reserve_index_i] == PEND_MAX);
    assign sb_error_o     = sb_error_q;

endmodule

// File: rtl/cpu_regfile.sv
// Architectural register file with two registered read ports and a pending-write
// scoreboard. Define REGFILE_BYPASS_EN to forward same-cycle commits to the read ports.
module cpu_regfile
    import cpu_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  reg_idx_t  read_index_a_i,
    input  reg_idx_t  read_index_b_i,
    output reg_data_t value_a_o,
    output reg_data_t value_b_o,
    input  reg_idx_t  register_write_index_i,
    input  logic      register_we_i,
    input  reg_data_t reg_result_i,
    input  logic      reserve_i,
    input  reg_idx_t  reserve_index_i,
    output logic      busy_a_o,
    output logic      busy_b_o,
    output logic      reserve_full_o,
    output logic      sb_error_o
);

    reg_data_t regs_q [NREGS];
    reg_data_t value_a_q;
    reg_data_t value_a_d;
    reg_data_t value_b_q;
    reg_data_t value_b_d;

    always_comb begin
        value_a_d = regs_q[read_index_a_i];
        value_b_d = regs_q[read_index_b_i];
`ifdef REGFILE_BYPASS_EN
        if (register_we_i && (register_write_index_i == read_index_a_i)) value_a_d = reg_result_i;
        if (register_we_i && (register_write_index_i == read_index_b_i)) value_b_d = reg_result_i;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
            value_a_q <= '0;
            value_b_q <= '0;
        end else begin
            if (register_we_i) regs_q[register_write_index_i] <= reg_result_i;
            value_a_q <= value_a_d;
            value_b_q <= value_b_d;
        end
    end

    assign value_a_o = value_a_q;
    assign value_b_o = value_b_q;

    cpu_scoreboard u_scoreboard (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .read_index_a_i  (read_index_a_i),
        .read_index_b_i  (read_index_b_i),
        .reserve_i       (reserve_i),
        .reserve_index_i (reserve_index_i),
        .commit_i        (register_we_i),
        .commit_index_i  (register_write_index_i),
        .busy_a_o        (busy_a_o),
        .busy_b_o        (busy_b_o),
        .reserve_full_o  (reserve_full_o),
        .sb_error_o      (sb_error_o)
    );

endmodule

// File: tb/tb_cpu_regfile.sv
// Self-checking bench for cpu_regfile: directed scenarios plus randomized traffic
// checked against an array-based reference model.
module tb_cpu_regfile;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  ra, rb, widx, ridx;
    logic        we, resv;
    logic [31:0] res;
    logic [31:0] value_a_o, value_b_o;
    logic        busy_a_o, busy_b_o, reserve_full_o, sb_error_o;

    logic [31:0] regs_m [16];
    int          pend_m [16];
    bit          err_m;
    logic [31:0] exp_a, exp_b;
    int          tests_run = 0;
    int          tests_failed = 0;

    always #5 clk_i = ~clk_i;

    cpu_regfile dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .read_index_a_i         (ra),
        .read_index_b_i         (rb),
        .value_a_o              (value_a_o),
        .value_b_o              (value_b_o),
        .register_write_index_i (widx),
        .register_we_i          (we),
        .reg_result_i           (res),
        .reserve_i              (resv),
        .reserve_index_i        (ridx),
        .busy_a_o               (busy_a_o),
        .busy_b_o               (busy_b_o),
        .reserve_full_o         (reserve_full_o),
        .sb_error_o             (sb_error_o)
    );

    task automatic model_reset();
        for (int r = 0; r < 16; r++) begin
            regs_m[r] = '0;
            pend_m[r] = 0;
        end
        err_m = 1'b0;
        exp_a = '0;
        exp_b = '0;
    endtask

    task automatic idle();
        we = 1'b0; resv = 1'b0; widx = '0; ridx = '0; res = '0;
    endtask

    // Advance one clock edge, updating the model from the inputs held across it.
    task automatic cycle();
        logic [31:0] na, nb;
        na = regs_m[ra];
        nb = regs_m[rb];
`ifdef REGFILE_BYPASS_EN
        if (we && widx == ra) na = res;
        if (we && widx == rb) nb = res;
`endif
        if (!(resv && we && ridx == widx)) begin
            if (resv) begin
                if (pend_m[ridx] == 3) err_m = 1'b1;
                else pend_m[ridx] = pend_m[ridx] + 1;
            end
            if (we) begin
                if (pend_m[widx] == 0) err_m = 1'b1;
                else pend_m[widx] = pend_m[widx] - 1;
            end
        end
        if (we) regs_m[widx] = res;
        @(posedge clk_i);
        #1;
        exp_a = na;
        exp_b = nb;
    endtask

    task automatic do_reset();
        idle();
        rst_i = 1'b0;
        #3;
        model_reset();
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        idle();
        ra = 4'd5; rb = 4'd3;
        rst_i = 1'b0;
        #7;
        model_reset();
        tests_run++;
        if ({value_a_o, value_b_o, busy_a_o, busy_b_o, reserve_full_o, sb_error_o} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: got a=%h b=%h flags=%b%b%b%b want all 0", value_a_o,
                     value_b_o, busy_a_o, busy_b_o, reserve_full_o, sb_error_o);
        end
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        // Mid-operation reset.
        we = 1'b1; widx = 4'd5; res = 32'hDEADBEEF;
        cycle();
        idle();
        resv = 1'b1; ridx = 4'd3;
        cycle();
        idle();
        cycle();
        tests_run++;
        if (value_a_o !== 32'hDEADBEEF || busy_b_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_setup: got a=%h busy=%b want deadbeef 1", value_a_o, busy_b_o);
        end
        rst_i = 1'b0;
        #2;
        model_reset();
        tests_run++;
        if (value_a_o !== 32'h0 || value_b_o !== 32'h0 || busy_b_o !== 1'b0 ||
            sb_error_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset: got a=%h b=%h busy=%b err=%b want 0 0 0 0", value_a_o,
                     value_b_o, busy_b_o, sb_error_o);
        end
        rst_i = 1'b1;
        cycle();
        tests_run++;
        if (value_a_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL r5_after_reset: got %h want 00000000", value_a_o);
        end
    endtask

    task automatic test_write_read();
        do_reset();
        we = 1'b1; widx = 4'd7; res = 32'h12345678;
        cycle();
        idle();
        ra = 4'd7; rb = 4'd7;
        cycle();
        tests_run++;
        if (value_a_o !== 32'h12345678 || value_b_o !== 32'h12345678) begin
            tests_failed++;
            $display("FAIL write_read: got a=%h b=%h want 12345678", value_a_o, value_b_o);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] want;
`ifdef REGFILE_BYPASS_EN
        want = 32'hA5A5A5A5;
`else
        want = 32'h0;
`endif
        do_reset();
        rb = 4'd2; ra = 4'd0;
        we = 1'b1; widx = 4'd2; res = 32'hA5A5A5A5;
        cycle();
        idle();
        tests_run++;
        if (value_b_o !== want) begin
            tests_failed++;
            $display("FAIL bypass: got %h want %h", value_b_o, want);
        end
        cycle();
        tests_run++;
        if (value_b_o !== 32'hA5A5A5A5) begin
            tests_failed++;
            $display("FAIL bypass_next: got %h want a5a5a5a5", value_b_o);
        end
    endtask

    task automatic test_counting();
        do_reset();
        ra = 4'd4;
        for (int i = 0; i < 3; i++) begin
            resv = 1'b1; ridx = 4'd4;
            cycle();
        end
        tests_run++;
        if (reserve_full_o !== 1'b1 || busy_a_o !== 1'b1 || sb_error_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_at_3: got full=%b busy=%b err=%b want 1 1 0", reserve_full_o,
                     busy_a_o, sb_error_o);
        end
        cycle();
        tests_run++;
        if (sb_error_o !== 1'b1 || reserve_full_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow: got err=%b full=%b want 1 1", sb_error_o, reserve_full_o);
        end
        idle();
        ridx = 4'd4;
        for (int i = 0; i < 3; i++) begin
            we = 1'b1; widx = 4'd4; res = 32'(i);
            cycle();
            tests_run++;
            if (busy_a_o !== (i < 2) || reserve_full_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL drain_%0d: got busy=%b full=%b want %b 0", i, busy_a_o,
                         reserve_full_o, i < 2);
            end
        end
        idle();
    endtask

    task automatic test_simultaneous();
        do_reset();
        ra = 4'd9; rb = 4'd10;
        resv = 1'b1; ridx = 4'd9;
        cycle();
        we = 1'b1; widx = 4'd9; res = 32'h99;
        cycle();
        tests_run++;
        if (busy_a_o !== 1'b1 || sb_error_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL simul_r9: got busy=%b err=%b want 1 0", busy_a_o, sb_error_o);
        end
        // Zero-pending register: combined reserve+commit must not flag an error.
        ridx = 4'd10; widx = 4'd10; res = 32'hAA;
        cycle();
        idle();
        tests_run++;
        if (busy_b_o !== 1'b0 || sb_error_o !== 1'b0 || busy_a_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL simul_r10: got busy_b=%b err=%b busy_a=%b want 0 0 1", busy_b_o,
                     sb_error_o, busy_a_o);
        end
    endtask

    task automatic test_spurious();
        do_reset();
        we = 1'b1; widx = 4'd1; res = 32'hCAFE0001;
        cycle();
        idle();
        ra = 4'd1;
        cycle();
        tests_run++;
        if (sb_error_o !== 1'b1 || value_a_o !== 32'hCAFE0001) begin
            tests_failed++;
            $display("FAIL spurious: got err=%b a=%h want 1 cafe0001", sb_error_o, value_a_o);
        end
        for (int i = 0; i < 4; i++) cycle();
        tests_run++;
        if (sb_error_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL sticky: got err=%b want 1", sb_error_o);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            ra   = 4'($urandom_range(0, 15));
            rb   = ($urandom_range(0, 7) == 0) ? ra : 4'($urandom_range(0, 15));
            ridx = 4'($urandom_range(0, 15));
            widx = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15));
            res  = $urandom;
            resv = (pend_m[ridx] < 3 || $urandom_range(0, 31) == 0) && $urandom_range(0, 1) == 1;
            we   = (pend_m[widx] > 0 || $urandom_range(0, 31) == 0) && $urandom_range(0, 1) == 1;
            #1;
            tests_run++;
            if (busy_a_o !== (pend_m[ra] != 0) || busy_b_o !== (pend_m[rb] != 0) ||
                reserve_full_o !== (pend_m[ridx] == 3) || sb_error_o !== err_m) begin
                tests_failed++;
                $display("FAIL rand_flags[%0d]: got %b%b%b%b want %b%b%b%b", n, busy_a_o,
                         busy_b_o, reserve_full_o, sb_error_o, pend_m[ra] != 0,
                         pend_m[rb] != 0, pend_m[ridx] == 3, err_m);
            end
            cycle();
            tests_run++;
            if (value_a_o !== exp_a || value_b_o !== exp_b) begin
                tests_failed++;
                $display("FAIL rand_data[%0d]: got a=%h b=%h want a=%h b=%h", n, value_a_o,
                         value_b_o, exp_a, exp_b);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        ra = '0; rb = '0;
        model_reset();
        test_reset();
        test_write_read();
        test_bypass();
        test_counting();
        test_simultaneous();
        test_spurious();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
